// File: rtl/mem_store_request_pkg.sv
// rtl/mem_store_request_pkg.sv - shared constants and types for the store request engine
package mem_store_request_pkg;

    localparam int ST_OP_W   = 5;
    localparam int ST_OP_SW  = 0;
    localparam int ST_OP_SH  = 1;
    localparam int ST_OP_SB  = 2;
    localparam int ST_OP_SWL = 3;
    localparam int ST_OP_SWR = 4;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } st_state_e;

endpackage

// File: rtl/mem_store_request_store_format.sv
// rtl/mem_store_request_store_format.sv - combinational store data/strobe/size formatter
module store_format
    import mem_store_request_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ST_OP_W-1:0]  i_st_op,
    input  logic [1:0]          i_ea,
    input  logic [DATA_W-1:0]   i_st_data,
    input  logic [ADDR_W-1:0]   i_st_addr,
    output logic [1:0]          o_size,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_misaligned
);

    logic [ADDR_W-1:0] w_word_addr;

    assign w_word_addr  = {i_st_addr[ADDR_W-1:2], 2'b00};
    assign o_misaligned = (i_st_op[ST_OP_SW] & (i_ea != 2'b00)) |
                          (i_st_op[ST_OP_SH] & i_ea[0]);

    always_comb begin
        o_size  = SIZE_WORD;
        o_addr  = i_st_addr;
        o_wdata = i_st_data;
        o_wstrb = 4'b0000;
        if (i_st_op[ST_OP_SB]) begin
            o_size  = SIZE_BYTE;
            o_wdata = {4{i_st_data[7:0]}};
            o_wstrb = 4'b0001 << i_ea;
        end else if (i_st_op[ST_OP_SH]) begin
            o_size  = SIZE_HALF;
            o_wdata = {2{i_st_data[15:0]}};
            o_wstrb = i_ea[1] ? 4'b1100 : 4'b0011;
        end else if (i_st_op[ST_OP_SW]) begin
            o_wstrb = 4'b1111;
        end else if (i_st_op[ST_OP_SWL]) begin
            // SWL writes the high-order bytes of rt into the low lanes up to ea
            o_addr = w_word_addr;
            case (i_ea)
                2'd0:    begin o_wstrb = 4'b0001; o_wdata = {24'b0, i_st_data[31:24]}; end
                2'd1:    begin o_wstrb = 4'b0011; o_wdata = {16'b0, i_st_data[31:16]}; end
                2'd2:    begin o_wstrb = 4'b0111; o_wdata = {8'b0,  i_st_data[31:8]};  end
                default: begin o_wstrb = 4'b1111; o_wdata = i_st_data;                 end
            endcase
        end else if (i_st_op[ST_OP_SWR]) begin
            o_addr = w_word_addr;
            case (i_ea)
                2'd0:    begin o_wstrb = 4'b1111; o_wdata = i_st_data;                 end
                2'd1:    begin o_wstrb = 4'b1110; o_wdata = {i_st_data[23:0], 8'b0};  end
                2'd2:    begin o_wstrb = 4'b1100; o_wdata = {i_st_data[15:0], 16'b0}; end
                default: begin o_wstrb = 4'b1000; o_wdata = {i_st_data[7:0], 24'b0};  end
            endcase
        end
    end

endmodule

// File: rtl/mem_store_request.sv
// rtl/mem_store_request.sv - store-side SRAM-like request engine with AdES detection
module mem_store_request
    import mem_store_request_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [ST_OP_W-1:0]  st_op,
    input  logic [ADDR_W-1:0]   st_addr,
    input  logic [DATA_W-1:0]   st_data,
    input  logic                flush,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W/8-1:0] data_wstrb,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    output logic                st_done,
    output logic                ades_ex,
    output logic [ADDR_W-1:0]   st_badvaddr
);

    st_state_e           r_state;
    logic                r_req;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_done;
    logic                r_ades;
    logic [ADDR_W-1:0]   r_badvaddr;
    logic                r_cancel;

    logic                w_accept;
    logic [1:0]          w_fmt_size;
    logic [ADDR_W-1:0]   w_fmt_addr;
    logic [DATA_W-1:0]   w_fmt_wdata;
    logic [DATA_W/8-1:0] w_fmt_wstrb;
    logic                w_fmt_misaligned;

    store_format #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store_format (
        .i_st_op      (st_op),
        .i_ea         (st_addr[1:0]),
        .i_st_data    (st_data),
        .i_st_addr    (st_addr),
        .o_size       (w_fmt_size),
        .o_addr       (w_fmt_addr),
        .o_wdata      (w_fmt_wdata),
        .o_wstrb      (w_fmt_wstrb),
        .o_misaligned (w_fmt_misaligned)
    );

    assign st_ready    = (r_state == ST_IDLE) & ~flush;
    assign w_accept    = st_valid & st_ready;
    assign data_req    = r_req;
    assign data_wr     = 1'b1;
    assign data_size   = r_size;
    assign data_addr   = r_addr;
    assign data_wdata  = r_wdata;
    assign data_wstrb  = r_wstrb;
    assign st_done     = r_done;
    assign ades_ex     = r_ades;
    assign st_badvaddr = r_badvaddr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_done     <= 1'b0;
            r_ades     <= 1'b0;
            r_badvaddr <= '0;
            r_cancel   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ades <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cancel <= 1'b0;
                    if (w_accept) begin
                        if (w_fmt_misaligned) begin
                            r_done     <= 1'b1;
                            r_ades     <= 1'b1;
                            r_badvaddr <= st_addr;
                        end else begin
                            r_req   <= 1'b1;
                            r_size  <= w_fmt_size;
                            r_addr  <= w_fmt_addr;
                            r_wdata <= w_fmt_wdata;
                            r_wstrb <= w_fmt_wstrb;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A flush cannot withdraw data_req before addr_ok; it only hides the completion
                    if (data_addr_ok) begin
                        r_req <= 1'b0;
                        if (data_data_ok) begin
                            r_state  <= ST_IDLE;
                            r_done   <= ~(r_cancel | flush);
                            r_cancel <= 1'b0;
                        end else begin
                            r_state  <= ST_WAIT;
                            r_cancel <= r_cancel | flush;
                        end
                    end else begin
                        r_cancel <= r_cancel | flush;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        r_state  <= ST_IDLE;
                        r_done   <= ~(r_cancel | flush);
                        r_cancel <= 1'b0;
                    end else begin
                        r_cancel <= r_cancel | flush;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_request.sv
// tb/tb_mem_store_request.sv - scoreboard bench for mem_store_request
module tb_mem_store_request;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        mis;
    } req_t;

    typedef struct packed {
        logic        ades;
        logic [31:0] addr;
    } done_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [4:0]  st_op = 5'b0;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic        flush = 1'b0;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic        st_done;
    logic        ades_ex;
    logic [31:0] st_badvaddr;

    int n_checks = 0;
    int n_errors = 0;
    req_t  req_q[$];
    done_t done_q[$];

    mem_store_request #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_op        (st_op),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .flush        (flush),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .st_done      (st_done),
        .ades_ex      (ades_ex),
        .st_badvaddr  (st_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic req_t model(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_t m;
        int   e;
        e       = int'(addr[1:0]);
        m.addr  = addr;
        m.size  = 2'd2;
        m.wdata = data;
        m.wstrb = 4'hF;
        m.mis   = 1'b0;
        if (op[2]) begin
            m.size  = 2'd0;
            m.wdata = {data[7:0], data[7:0], data[7:0], data[7:0]};
            for (int i = 0; i < 4; i++) m.wstrb[i] = (i == e);
        end else if (op[1]) begin
            m.size  = 2'd1;
            m.wdata = {data[15:0], data[15:0]};
            m.wstrb = (e >= 2) ? 4'hC : 4'h3;
            m.mis   = (e % 2) != 0;
        end else if (op[0]) begin
            m.mis = (e != 0);
        end else if (op[3]) begin
            m.addr  = {addr[31:2], 2'b00};
            m.wdata = data >> (8 * (3 - e));
            m.wstrb = 4'hF >> (3 - e);
        end else begin
            m.addr  = {addr[31:2], 2'b00};
            m.wdata = data << (8 * e);
            m.wstrb = 4'((4'hF << e) & 4'hF);
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (data_req && data_addr_ok) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 32'(req_q.size()), 32'd1);
            end else begin
                req_t e;
                e = req_q.pop_front();
                chk("req_wr", 32'(data_wr), 32'd1);
                chk("req_size", 32'(data_size), 32'(e.size));
                chk("req_addr", data_addr, e.addr);
                chk("req_wdata", data_wdata, e.wdata);
                chk("req_wstrb", 32'(data_wstrb), 32'(e.wstrb));
            end
        end
        if (st_done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'(done_q.size()), 32'd1);
            end else begin
                done_t d;
                d = done_q.pop_front();
                chk("done_ades", 32'(ades_ex), 32'(d.ades));
                if (d.ades) chk("badvaddr", st_badvaddr, d.addr);
            end
        end else if (ades_ex) begin
            chk("ades_without_done", 32'(st_done), 32'd1);
        end
    end

    task automatic do_store(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input req_t exp, input int aw, input int dgap, input bit fl);
        chk("st_ready", 32'(st_ready), 32'd1);
        st_valid = 1'b1; st_op = op; st_addr = addr; st_data = data;
        if (exp.mis) done_q.push_back({1'b1, addr});
        @(posedge clk); #1;
        st_valid = 1'b0;
        if (exp.mis) begin
            chk("mis_done", 32'(st_done), 32'd1);
            chk("mis_noreq", 32'(data_req), 32'd0);
            @(posedge clk); #1;
            chk("mis_pulse", 32'(st_done), 32'd0);
            chk("mis_noreq2", 32'(data_req), 32'd0);
            return;
        end
        req_q.push_back(exp);
        if (!fl) done_q.push_back({1'b0, 32'h0});
        chk("req_next_cycle", 32'(data_req), 32'd1);
        for (int i = 0; i < aw; i++) begin
            chk("hold_req", 32'(data_req), 32'd1);
            chk("hold_addr", data_addr, exp.addr);
            chk("hold_size", 32'(data_size), 32'(exp.size));
            chk("hold_wstrb", 32'(data_wstrb), 32'(exp.wstrb));
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b1;
        data_data_ok = (dgap == 0);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (dgap > 0) begin
            if (fl) flush = 1'b1;
            for (int i = 1; i < dgap; i++) begin
                chk("wait_noreq", 32'(data_req), 32'd0);
                @(posedge clk); #1;
            end
            chk("wait_noreq", 32'(data_req), 32'd0);
            chk("wait_done_low", 32'(st_done), 32'd0);
            data_data_ok = 1'b1;
            @(posedge clk); #1;
            data_data_ok = 1'b0;
        end
        chk("done_after_dok", 32'(st_done), fl ? 32'd0 : 32'd1);
        chk("noreq_after", 32'(data_req), 32'd0);
        flush = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", 32'(st_done), 32'd0);
        chk("ready_back", 32'(st_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] d;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_wr", 32'(data_wr), 32'd1);
        chk("rst_done", 32'(st_done), 32'd0);
        chk("rst_ades", 32'(ades_ex), 32'd0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wdata", data_wdata, 32'h0);
        chk("rst_wstrb", 32'(data_wstrb), 32'h0);
        chk("rst_size", 32'(data_size), 32'h0);
        chk("rst_badv", st_badvaddr, 32'h0);
        chk("rst_ready", 32'(st_ready), 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        do_store(5'b00100, 32'h0000_1003, 32'h0000_00A5,
                 {2'd0, 32'h0000_1003, 32'hA5A5_A5A5, 4'b1000, 1'b0}, 0, 1, 1'b0);
        do_store(5'b01000, 32'h0000_2001, 32'h1122_3344,
                 {2'd2, 32'h0000_2000, 32'h0000_1122, 4'b0011, 1'b0}, 0, 0, 1'b0);
        do_store(5'b10000, 32'h0000_2002, 32'h1122_3344,
                 {2'd2, 32'h0000_2000, 32'h3344_0000, 4'b1100, 1'b0}, 1, 1, 1'b0);
        do_store(5'b00001, 32'h0000_3002, 32'h5555_AAAA,
                 {2'd2, 32'h0000_3002, 32'h5555_AAAA, 4'b1111, 1'b1}, 0, 0, 1'b0);
        do_store(5'b00010, 32'h0000_4002, 32'hDEAD_BEEF,
                 {2'd1, 32'h0000_4002, 32'hBEEF_BEEF, 4'b1100, 1'b0}, 3, 0, 1'b0);
        do_store(5'b00001, 32'h0000_5004, 32'h1234_5678,
                 {2'd2, 32'h0000_5004, 32'h1234_5678, 4'b1111, 1'b0}, 1, 2, 1'b1);

        flush = 1'b1; st_valid = 1'b1; st_op = 5'b00001; st_addr = 32'h7000; st_data = 32'h1;
        #1;
        chk("flush_idle_ready", 32'(st_ready), 32'd0);
        @(posedge clk); #1;
        st_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_noreq", 32'(data_req), 32'd0);
        @(posedge clk); #1;
        chk("flush_idle_noreq2", 32'(data_req), 32'd0);

        data_data_ok = 1'b1;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        chk("idle_dok_ignored", 32'(st_done), 32'd0);

        for (int n = 0; n < 24; n++) begin
            op = 5'(1 << $urandom_range(0, 4));
            a  = $urandom;
            d  = $urandom;
            do_store(op, a, d, model(op, a, d), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)), 1'b0);
        end

        st_valid = 1'b1; st_op = 5'b00001; st_addr = 32'h0000_6000; st_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        st_valid = 1'b0;
        chk("rst_mid_req_hi", 32'(data_req), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_req", 32'(data_req), 32'd0);
        chk("rst_async_done", 32'(st_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_after_ready", 32'(st_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_after_done", 32'(st_done), 32'd0);
        chk("rst_after_req", 32'(data_req), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
